// File: rtl/jk_mod_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jk_pkg
//  Description : JK excitation codes and the excitation function shared by
//                the modulo counter and its JK storage cells.
//                Codes are packed as {j,k}.
//  Revision    : 1.0 - initial release
// ============================================================================
package jk_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Excitation for one bit moving from cur to nxt. Only HOLD, SET and
    // RESET are ever produced; TOGGLE would need knowledge of cur at the
    // cell, which this scheme deliberately avoids.
    function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
        logic [1:0] code;
        if (cur == nxt) begin
            code = JK_HOLD;
        end else if (nxt) begin
            code = JK_SET;
        end else begin
            code = JK_RESET;
        end
        return code;
    endfunction

endpackage : jk_pkg
`default_nettype wire

// File: rtl/jk_mod_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : jk_mod_counter_if
//  Description : Control and status bundle of the JK modulo counter.
//                master : drives clr/load/d/en/up, observes counter outputs
//                slave  : the counter itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface jk_mod_counter_if #(
    parameter int WIDTH = 4
);
    import jk_pkg::*;

    logic             clr;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             en;
    logic             up;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
    logic             tc;
    logic             wrap;

    modport master (
        output clr, load, d, en, up,
        input  q, qbar, j_out, k_out, tc, wrap
    );

    modport slave (
        input  clr, load, d, en, up,
        output q, qbar, j_out, k_out, tc, wrap
    );

endinterface : jk_mod_counter_if
`default_nettype wire

// File: rtl/jk_mod_counter_cell.sv
`default_nettype none
// ============================================================================
//  Module      : jk_cell
//  Description : Single JK flip-flop, asynchronous active-low reset to 0.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset
//                j, k  - excitation inputs
//                q     - stored bit
//                qbar  - complement of q (derived, never stored separately)
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_cell
    import jk_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic j,
    input  wire logic k,
    output logic      q,
    output logic      qbar
);

    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else begin
            r_q <= (j & ~r_q) | (~k & r_q);
        end
    end

    assign q    = r_q;
    assign qbar = ~r_q;

endmodule : jk_cell
`default_nettype wire

// File: rtl/jk_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : jk_mod_counter
//  Description : Modulo-MODULUS up/down counter built from WIDTH JK cells.
//                Next state is chosen with priority clr > load > en > hold,
//                load values at or above MODULUS clamp to MODULUS-1, and each
//                bit's J/K excitation is derived from (q, next).
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset
//                bus   - slave side: clr, load, d, en, up in;
//                        q, qbar, j_out, k_out, tc, wrap out
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    jk_mod_counter_if.slave   bus
);

    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("jk_mod_counter: WIDTH must be 1..16");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("jk_mod_counter: MODULUS must be 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] c_MAX     = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is representable in the clamp compare.
    localparam logic [WIDTH:0]   c_MOD_EXT = (WIDTH+1)'(MODULUS);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qbar;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_wrap_evt;
    logic             r_wrap;

    assign w_at_max  = (w_q == c_MAX);
    assign w_at_zero = (w_q == '0);

    always_comb begin
        w_next     = w_q;
        w_wrap_evt = 1'b0;
        if (bus.clr) begin
            w_next = '0;
        end else if (bus.load) begin
            w_next = ({1'b0, bus.d} >= c_MOD_EXT) ? c_MAX : bus.d;
        end else if (bus.en) begin
            if (bus.up) begin
                if (w_at_max) begin
                    w_next     = '0;
                    w_wrap_evt = 1'b1;
                end else begin
                    w_next = w_q + WIDTH'(1);
                end
            end else begin
                if (w_at_zero) begin
                    w_next     = c_MAX;
                    w_wrap_evt = 1'b1;
                end else begin
                    w_next = w_q - WIDTH'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cells
        assign {w_j[i], w_k[i]} = jk_excite(w_q[i], w_next[i]);

        jk_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (w_j[i]),
            .k     (w_k[i]),
            .q     (w_q[i]),
            .qbar  (w_qbar[i])
        );
    end

    // Only en-driven wraps pulse wrap; clr/load never set w_wrap_evt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_evt;
        end
    end

    assign bus.q     = w_q;
    assign bus.qbar  = w_qbar;
    assign bus.j_out = w_j;
    assign bus.k_out = w_k;
    assign bus.tc    = bus.en & ~bus.clr & ~bus.load & (bus.up ? w_at_max : w_at_zero);
    assign bus.wrap  = r_wrap;

endmodule : jk_mod_counter
`default_nettype wire
